// File: rtl/pcileech_tx_pkg.sv
// Shared constants and tag type for the pcileech TX frame packer.
package pcileech_tx_pkg;

  localparam logic [3:0]  HDR_MAGIC = 4'hE;
  localparam logic [3:0]  TAG_EMPTY = 4'hF;
  localparam logic [31:0] PAD_DWORD = 32'h0;
  localparam int          SLOTS     = 7;

  typedef struct packed {
    logic [1:0] port;
    logic [1:0] ctx;
  } tag_t;

  // Port 3 with ctx 3 would alias TAG_EMPTY, so its context is demoted to 2.
  function automatic tag_t make_tag(input logic [1:0] port, input logic [1:0] ctx);
    tag_t t;
    t.port = port;
    t.ctx  = (port == 2'd3 && ctx == 2'b11) ? 2'b10 : ctx;
    return t;
  endfunction

endpackage

// File: rtl/pcileech_tx_arb.sv
// Combinational 4-way fixed-priority arbiter: port 0 wins, port 3 loses.
module pcileech_tx_arb (
  input  logic [3:0] valid_i,
  output logic [3:0] ready_o,
  output logic [1:0] sel_o,
  output logic       any_o
);

  always_comb begin
    ready_o = 4'b0000;
    sel_o   = 2'd0;
    any_o   = |valid_i;
    if (valid_i[0]) begin
      ready_o = 4'b0001;
      sel_o   = 2'd0;
    end else if (valid_i[1]) begin
      ready_o = 4'b0010;
      sel_o   = 2'd1;
    end else if (valid_i[2]) begin
      ready_o = 4'b0100;
      sel_o   = 2'd2;
    end else if (valid_i[3]) begin
      ready_o = 4'b1000;
      sel_o   = 2'd3;
    end
  end

endmodule

// File: rtl/pcileech_tx_packer.sv
// Packs four prioritized 34-bit streams into 256-bit header+7-slot frames.
// Optional statistics counters: define PCILEECH_TX_PACKER_STATS_EN.
module pcileech_tx_packer
  import pcileech_tx_pkg::*;
#(
  parameter int FLUSH_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [33:0]  p0_din,
  input  logic         p0_valid,
  output logic         p0_ready,
  input  logic [33:0]  p1_din,
  input  logic         p1_valid,
  output logic         p1_ready,
  input  logic [33:0]  p2_din,
  input  logic         p2_valid,
  output logic         p2_ready,
  input  logic [33:0]  p3_din,
  input  logic         p3_valid,
  output logic         p3_ready,
  output logic [255:0] dout,
  output logic         valid,
`ifdef PCILEECH_TX_PACKER_STATS_EN
  output logic [31:0]  stat_frames,
  output logic [15:0]  stat_flushes,
`endif
  output logic [2:0]   dbg_fill_cnt
);

  // Handshake: a word moves when pN_valid & pN_ready; ready is combinational,
  // granted to the lowest-numbered valid port only, and forced low in reset.

  localparam logic [2:0]  LAST_SLOT = 3'(SLOTS - 1);
  localparam logic [15:0] IDLE_LAST = 16'(FLUSH_CYCLES - 1);

  logic [3:0]   arb_ready;
  logic [1:0]   sel;
  logic         any_valid;
  logic         accept;
  logic [33:0]  sel_din;
  tag_t         new_tag;

  logic [31:0]  pay_q [SLOTS];
  logic [31:0]  pay_d [SLOTS];
  logic [3:0]   tag_q [SLOTS];
  logic [3:0]   tag_d [SLOTS];
  logic [31:0]  ins_pay [SLOTS];
  logic [3:0]   ins_tag [SLOTS];
  logic [2:0]   fill_q, fill_d;
  logic [15:0]  idle_q, idle_d;
  logic         valid_q, valid_d;
  logic [255:0] dout_q, dout_d;
  logic [255:0] frame;
  logic         full_now, flush_now, emit;

  pcileech_tx_arb u_arb (
    .valid_i ({p3_valid, p2_valid, p1_valid, p0_valid}),
    .ready_o (arb_ready),
    .sel_o   (sel),
    .any_o   (any_valid)
  );

  assign {p3_ready, p2_ready, p1_ready, p0_ready} = rst ? 4'b0000 : arb_ready;
  assign accept = any_valid & ~rst;

  always_comb begin
    case (sel)
      2'd0:    sel_din = p0_din;
      2'd1:    sel_din = p1_din;
      2'd2:    sel_din = p2_din;
      default: sel_din = p3_din;
    endcase
  end

  assign new_tag = make_tag(sel, sel_din[33:32]);

  // The frame is assembled from the slot view that already contains this
  // cycle's word, so the 7th accept and its emit share one edge.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      ins_pay[i] = pay_q[i];
      ins_tag[i] = tag_q[i];
    end
    if (accept) begin
      ins_pay[fill_q] = sel_din[31:0];
      ins_tag[fill_q] = new_tag;
    end
    frame        = '0;
    frame[31:28] = HDR_MAGIC;
    for (int i = 0; i < SLOTS; i++) begin
      frame[4*i +: 4]       = ins_tag[i];
      frame[32*(i+1) +: 32] = ins_pay[i];
    end
  end

  always_comb begin
    full_now  = accept && (fill_q == LAST_SLOT);
    flush_now = !accept && (fill_q != 3'd0) && (idle_q == IDLE_LAST);
    emit      = full_now || flush_now;

    fill_d = fill_q;
    for (int i = 0; i < SLOTS; i++) begin
      pay_d[i] = ins_pay[i];
      tag_d[i] = ins_tag[i];
    end
    if (emit) begin
      fill_d = 3'd0;
      for (int i = 0; i < SLOTS; i++) begin
        pay_d[i] = PAD_DWORD;
        tag_d[i] = TAG_EMPTY;
      end
    end else if (accept) begin
      fill_d = fill_q + 3'd1;
    end

    if (accept || emit || (fill_q == 3'd0)) idle_d = 16'd0;
    else                                    idle_d = idle_q + 16'd1;

    valid_d = emit;
    dout_d  = emit ? frame : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q  <= 3'd0;
      idle_q  <= 16'd0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        pay_q[i] <= PAD_DWORD;
        tag_q[i] <= TAG_EMPTY;
      end
    end else begin
      fill_q  <= fill_d;
      idle_q  <= idle_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      for (int i = 0; i < SLOTS; i++) begin
        pay_q[i] <= pay_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign dbg_fill_cnt = fill_q;

`ifdef PCILEECH_TX_PACKER_STATS_EN
  logic [31:0] frames_q;
  logic [15:0] flushes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_q  <= 32'd0;
      flushes_q <= 16'd0;
    end else begin
      if (emit)      frames_q  <= frames_q + 32'd1;
      if (flush_now) flushes_q <= flushes_q + 16'd1;
    end
  end

  assign stat_frames  = frames_q;
  assign stat_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_pcileech_tx_packer.sv
// Bench for pcileech_tx_packer: frame-level reference model plus directed literals.
module tb_pcileech_tx_packer;

  localparam int F = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [33:0]  din [4];
  logic [3:0]   vld = 4'b0000;
  logic [3:0]   rdy;
  logic [255:0] dout;
  logic         valid;
  logic [2:0]   dbg_fill;
`ifdef PCILEECH_TX_PACKER_STATS_EN
  logic [31:0]  stat_frames;
  logic [15:0]  stat_flushes;
`endif

  pcileech_tx_packer #(.FLUSH_CYCLES(F)) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_din       (din[0]),
    .p0_valid     (vld[0]),
    .p0_ready     (rdy[0]),
    .p1_din       (din[1]),
    .p1_valid     (vld[1]),
    .p1_ready     (rdy[1]),
    .p2_din       (din[2]),
    .p2_valid     (vld[2]),
    .p2_ready     (rdy[2]),
    .p3_din       (din[3]),
    .p3_valid     (vld[3]),
    .p3_ready     (rdy[3]),
    .dout         (dout),
    .valid        (valid),
`ifdef PCILEECH_TX_PACKER_STATS_EN
    .stat_frames  (stat_frames),
    .stat_flushes (stat_flushes),
`endif
    .dbg_fill_cnt (dbg_fill)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard and model state
  logic [255:0] exp_q[$];
  logic [35:0]  cur_q[$];
  int           idle_m = 0;
  int           m_frames = 0;
  int           m_flushes = 0;
  int           frames_seen = 0;
  int           last_acc_cyc = 0;
  int           last_valid_cyc = 0;
  int           prev_valid_cyc = 0;
  logic [255:0] last_frame = '0;

  function automatic logic [255:0] build_frame();
    logic [255:0] f;
    f = '0;
    f[31:28] = 4'hE;
    for (int i = 0; i < 7; i++) begin
      if (i < cur_q.size()) begin
        f[4*i +: 4]       = cur_q[i][35:32];
        f[32*(i+1) +: 32] = cur_q[i][31:0];
      end else begin
        f[4*i +: 4] = 4'hF;
      end
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endtask

  // One clock: check ready and advance the model at negedge, check outputs after posedge.
  task automatic step();
    logic [3:0]   exp_rdy;
    logic [1:0]   ctx;
    logic [255:0] exp_f;
    int           p;
    @(negedge clk);
    exp_rdy = 4'b0000;
    p = -1;
    if (!rst) begin
      for (int i = 0; i < 4; i++) if (vld[i] && p < 0) p = i;
    end
    if (p >= 0) exp_rdy[p] = 1'b1;
    check("ready", 256'(rdy), 256'(exp_rdy));
    if (rst) begin
      cur_q.delete();
      idle_m = 0;
      m_frames = 0;
      m_flushes = 0;
    end else if (p >= 0) begin
      ctx = din[p][33:32];
      if (p == 3 && ctx == 2'b11) ctx = 2'b10;
      cur_q.push_back({2'(p), ctx, din[p][31:0]});
      idle_m = 0;
      last_acc_cyc = cyc + 1;
      if (cur_q.size() == 7) begin
        exp_q.push_back(build_frame());
        cur_q.delete();
        m_frames++;
      end
    end else if (cur_q.size() > 0) begin
      idle_m++;
      if (idle_m == F) begin
        exp_q.push_back(build_frame());
        cur_q.delete();
        idle_m = 0;
        m_frames++;
        m_flushes++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      check("rst_valid", 256'(valid), 256'(0));
      check("rst_dout", dout, 256'(0));
      last_frame = '0;
    end else begin
      check("valid", 256'(valid), 256'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        exp_f = exp_q.pop_front();
        if (valid) check("frame", dout, exp_f);
      end
      if (valid) begin
        frames_seen++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc + 1;
        last_frame = dout;
      end else begin
        check("dout_hold", dout, last_frame);
      end
    end
  endtask

  // Driver tasks
  task automatic drive(input int p, input logic [1:0] ctx, input logic [31:0] d);
    din[p] = {ctx, d};
    vld[p] = 1'b1;
  endtask

  task automatic idle(input int n);
    vld = 4'b0000;
    repeat (n) step();
  endtask

  initial begin
    int base;
    int mode;
    for (int i = 0; i < 4; i++) din[i] = '0;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    idle(2);

    // Seven words from port 0
    base = frames_seen;
    for (int i = 0; i < 7; i++) begin
      vld = 4'b0000;
      drive(0, 2'b00, 32'h100 + 32'(i));
      step();
    end
    vld = 4'b0000;
    check("t1_count", 256'(frames_seen - base), 256'(1));
    check("t1_header", 256'(last_frame[31:0]), 256'(32'hE000_0000));
    check("t1_slot0", 256'(last_frame[63:32]), 256'(32'h100));
    check("t1_slot6", 256'(last_frame[255:224]), 256'(32'h106));
    check("t1_latency", 256'(last_valid_cyc - last_acc_cyc), 256'(1));
    idle(3);

    // Ports 0 and 2 contend, then port 2 alone
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b00, 32'h200 + 32'(i));
      drive(2, 2'b00, 32'h300 + 32'(i));
      step();
    end
    vld[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2, 2'b00, 32'h300 + 32'(i));
      step();
    end
    vld = 4'b0000;
    check("t2_header", 256'(last_frame[31:0]), 256'(32'hE888_8000));
    check("t2_slot3", 256'(last_frame[159:128]), 256'(32'h300));
    idle(3);

    // Port 1 partial frame, flushed after idle timeout
    drive(1, 2'b00, 32'hA0);
    step();
    drive(1, 2'b00, 32'hA1);
    step();
    idle(F + 3);
    check("t3_header", 256'(last_frame[31:0]), 256'(32'hEFFF_FF44));
    check("t3_slot0", 256'(last_frame[63:32]), 256'(32'hA0));
    check("t3_pad", 256'(last_frame[255:96]), 256'(0));
    check("t3_latency", 256'(last_valid_cyc - last_acc_cyc), 256'(F + 1));

    // Port 3 with ctx 3 never produces the empty tag
    drive(3, 2'b11, 32'hC3);
    step();
    idle(F + 3);
    check("t4_header", 256'(last_frame[31:0]), 256'(32'hEFFF_FFFE));

    // Fourteen back-to-back words
    base = frames_seen;
    for (int i = 0; i < 14; i++) begin
      drive(0, 2'b01, 32'h400 + 32'(i));
      step();
    end
    idle(1);
    check("t5_count", 256'(frames_seen - base), 256'(2));
    check("t5_spacing", 256'(last_valid_cyc - prev_valid_cyc), 256'(7));
    check("t5_header", 256'(last_frame[31:0]), 256'(32'hE111_1111));
    check("t5_slot0", 256'(last_frame[63:32]), 256'(32'h407));
    idle(2);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 4; i++) begin
      drive(0, 2'b00, 32'h500 + 32'(i));
      step();
    end
    base = frames_seen;
    drive(0, 2'b00, 32'h5FF);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle(F + 3);
    check("t6_no_emit", 256'(frames_seen - base), 256'(0));
    for (int i = 0; i < 7; i++) begin
      drive(0, 2'b10, 32'h600 + 32'(i));
      step();
    end
    idle(1);
    check("t6_count", 256'(frames_seen - base), 256'(1));
    check("t6_header", 256'(last_frame[31:0]), 256'(32'hE222_2222));
    check("t6_slot0", 256'(last_frame[63:32]), 256'(32'h600));

    // Randomized traffic: busy, sparse and trickle phases with rare resets
    for (int blk = 0; blk < 30; blk++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 100; c++) begin
        for (int p = 0; p < 4; p++) din[p] = {2'($urandom_range(0, 3)), 32'($urandom())};
        case (mode)
          0:       vld = 4'($urandom_range(0, 15));
          1:       vld = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
          default: vld = ($urandom_range(0, 79) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
        endcase
        rst = ($urandom_range(0, 399) == 0);
        step();
      end
    end
    rst = 1'b0;
    idle(F + 5);

`ifdef PCILEECH_TX_PACKER_STATS_EN
    check("stat_frames", 256'(stat_frames), 256'(32'(m_frames)));
    check("stat_flushes", 256'(stat_flushes), 256'(16'(m_flushes)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
